// File: rtl/register_file_param.sv
// Parametrised register file: two registered read ports, one write port, optional
// hardwired-zero register, selectable write-first bypass and a hardware clear sweep.
module register_file_param #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  read_valid,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic                  valid_q, valid_d;
  logic                  access, wr_en;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Zero register and out-of-range addresses win over the bypass path.
  function automatic logic [DATA_WIDTH-1:0] read_value(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  fwd
  );
    if (!in_range(a) || is_zero(a)) return '0;
    if ((BYPASS != 0) && fwd && (write_reg == a)) return write_data;
    return stored;
  endfunction

  assign access = (state_q == S_IDLE) && En && !clear_req;
  assign wr_en  = access && reg_write && in_range(write_reg) && !is_zero(write_reg);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      valid_q <= valid_d;
    end
  end

  // Storage has no reset; the sweep is what zeroes it.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state_q == S_CLEAR) mem_q[idx_q] <= '0;
      else if (wr_en)         mem_q[write_reg] <= write_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    valid_d = 1'b0;
    if (access) begin
      rd1_d   = read_value(read_reg1, mem_q[read_reg1], wr_en);
      rd2_d   = read_value(read_reg2, mem_q[read_reg2], wr_en);
      valid_d = 1'b1;
    end
  end

  always_comb begin
    busy       = (state_q == S_CLEAR);
    read_valid = valid_q;
    read_data1 = rd1_q;
    read_data2 = rd2_q;
  end

endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: default instance (zero reg, bypass) alongside a
// DEPTH=20 read-first instance without zero register, both driven by the same inputs.
module tb_register_file_param;

  logic        Clk = 1'b0;
  logic        Rst, En, reg_write, clear_req;
  logic [4:0]  read_reg1, read_reg2, write_reg;
  logic [63:0] write_data;
  logic        busy_a, valid_a, busy_b, valid_b;
  logic [63:0] rd1_a, rd2_a, rd1_b, rd2_b;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  register_file_param dut_a (
    .Clk(Clk), .Rst(Rst), .En(En), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .clear_req(clear_req), .busy(busy_a), .read_valid(valid_a),
    .read_data1(rd1_a), .read_data2(rd2_a)
  );

  register_file_param #(.DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .En(En), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .clear_req(clear_req), .busy(busy_b), .read_valid(valid_b),
    .read_data1(rd1_b), .read_data2(rd2_b)
  );

  typedef struct {
    logic        en, we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  r1, r2;
    logic [63:0] a1, a2, b1, b2;
    logic        v;
  } vec_t;

  vec_t tbl[14];
  vec_t sb[$];

  function automatic vec_t mk(input logic en, input logic we, input logic [4:0] wa,
                              input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [63:0] a1, input logic [63:0] a2,
                              input logic [63:0] b1, input logic [63:0] b2, input logic v);
    vec_t t;
    t.en = en; t.we = we; t.wa = wa; t.wd = wd; t.r1 = r1; t.r2 = r2;
    t.a1 = a1; t.a2 = a2; t.b1 = b1; t.b2 = b2; t.v = v;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [4:0] wa,
                       input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic clr);
    En = en; reg_write = we; write_reg = wa; write_data = wd;
    read_reg1 = r1; read_reg2 = r2; clear_req = clr;
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic count_busy(output int ca, output int cb);
    ca = 0; cb = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      step();
    end
  endtask

  localparam logic [63:0] DB = 64'hDEAD_BEEF;

  initial begin
    int   ca, cb;
    vec_t e;

    tbl[0]  = mk(1, 1,  5, DB,        0,  0, 0,         0,         0,         0,     1);
    tbl[1]  = mk(1, 0,  0, 0,         5,  5, DB,        DB,        DB,        DB,    1);
    tbl[2]  = mk(1, 1,  7, 64'h1234,  7,  5, 64'h1234,  DB,        0,         DB,    1);
    tbl[3]  = mk(1, 1,  0, 64'hFFFF,  0,  0, 0,         0,         0,         0,     1);
    tbl[4]  = mk(1, 0,  0, 0,         0,  7, 0,         64'h1234,  64'hFFFF,  64'h1234, 1);
    tbl[5]  = mk(0, 1,  5, 64'h1111,  7,  7, 0,         64'h1234,  64'hFFFF,  64'h1234, 0);
    tbl[6]  = mk(1, 0,  0, 0,         5,  7, DB,        64'h1234,  DB,        64'h1234, 1);
    tbl[7]  = mk(1, 1, 31, 64'hAAAA, 31, 31, 64'hAAAA,  64'hAAAA,  0,         0,     1);
    tbl[8]  = mk(1, 1, 31, 64'hBBBB, 31,  0, 64'hBBBB,  0,         0,         64'hFFFF, 1);
    tbl[9]  = mk(1, 0,  0, 0,        31,  3, 64'hBBBB,  0,         0,         0,     1);
    tbl[10] = mk(1, 1, 20, 64'h5555, 20, 20, 64'h5555,  64'h5555,  0,         0,     1);
    tbl[11] = mk(1, 0,  0, 0,        20, 19, 64'h5555,  0,         0,         0,     1);
    tbl[12] = mk(1, 1, 19, 64'h6666, 19,  5, 64'h6666,  DB,        0,         DB,    1);
    tbl[13] = mk(1, 0,  0, 0,        19,  7, 64'h6666,  64'h1234,  64'h6666,  64'h1234, 1);

    Rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    @(negedge Clk);
    chk("reset busy_a", 64'(busy_a), 1);
    chk("reset busy_b", 64'(busy_b), 1);
    chk("reset valid", 64'(valid_a), 0);
    chk("reset rd1", rd1_a, 0);
    chk("reset rd2", rd2_a, 0);
    Rst = 1'b0;
    count_busy(ca, cb);
    chk("reset sweep len a", 64'(ca), 32);
    chk("reset sweep len b", 64'(cb), 20);

    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].en, tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].r1, tbl[k].r2, 0);
      sb.push_back(tbl[k]);
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d rd1_a", k), rd1_a, e.a1);
      chk($sformatf("vec%0d rd2_a", k), rd2_a, e.a2);
      chk($sformatf("vec%0d rd1_b", k), rd1_b, e.b1);
      chk($sformatf("vec%0d rd2_b", k), rd2_b, e.b2);
      chk($sformatf("vec%0d valid_a", k), 64'(valid_a), 64'(e.v));
      chk($sformatf("vec%0d valid_b", k), 64'(valid_b), 64'(e.v));
      chk($sformatf("vec%0d busy", k), 64'(busy_a | busy_b), 0);
    end

    // Fill, then clear while hammering writes and repeated clear requests.
    for (int i = 1; i < 32; i++) begin
      drive(1, 1, i[4:0], 64'h100 + 64'(i), 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 0, 1, 31, 0);
    step();
    chk("fill rd1_a", rd1_a, 64'h101);
    chk("fill rd2_a", rd2_a, 64'h11F);
    chk("fill rd1_b", rd1_b, 64'h101);
    chk("fill rd2_b", rd2_b, 0);
    drive(1, 1, 3, 64'h9999, 4, 4, 1);
    step();
    ca = 0; cb = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_a) ca++;
      if (busy_b) cb++;
      if (i < 32) begin
        chk($sformatf("sweep%0d valid_a", i), 64'(valid_a), 0);
        chk($sformatf("sweep%0d rd1_a hold", i), rd1_a, 64'h101);
      end
      if (i < 20) chk($sformatf("sweep%0d valid_b", i), 64'(valid_b), 0);
      if (i < 19) drive(1, 1, 2, 64'h7777, 2, 2, (i % 3) == 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end
    chk("clear sweep len a", 64'(ca), 32);
    chk("clear sweep len b", 64'(cb), 20);
    for (int i = 0; i < 32; i++) begin
      drive(1, 0, 0, 0, i[4:0], 5'(31 - i), 0);
      step();
      chk($sformatf("cleared r%0d a", i), rd1_a, 0);
      chk($sformatf("cleared r%0d a p2", 31 - i), rd2_a, 0);
      chk($sformatf("cleared r%0d b", i), rd1_b, 0);
    end

    // Reset re-asserted part way through a sweep restarts it from the beginning.
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    count_busy(ca, cb);
    chk("restart sweep len a", 64'(ca), 32);
    chk("restart sweep len b", 64'(cb), 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
